// File: rtl/spi_bpl_pkg.sv
// Shared definitions for the backplane SPI register bank.
//   state_t     : frame FSM states
//   CMD_W/RW_BIT: command byte width and read/write flag position
//   SYNC_STAGES : depth of the pin synchronisers
//   adr_w(n)    : channel index width, never below 1
package spi_bpl_pkg;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_RD,
      ST_WR,
      ST_SKIP
   } state_t;

   localparam int CMD_W       = 8;
   localparam int RW_BIT      = 7;
   localparam int SYNC_STAGES = 3;

   function automatic int adr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/spi_bpl_sync.sv
// Three-stage synchroniser with edge decode for one asynchronous pin.
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous pin
//   lvl      : synchronised level
//   rise/fall: one-cycle pulses decoded from the two oldest stages
module spi_bpl_sync
   import spi_bpl_pkg::*;
#(
   parameter logic INIT = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic lvl,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sh;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sh <= {SYNC_STAGES{INIT}};
      else     sh <= {sh[SYNC_STAGES-2:0], din};
   end

   assign lvl  = sh[1];
   assign rise = sh[1] & ~sh[2];
   assign fall = ~sh[1] & sh[2];
endmodule

// File: rtl/spi_regbank_bpl.sv
// SPI mode-0 slave register bank for the backplane link. A frame is an
// 8-bit command (bit 7 = write, bits 6:0 = start address) followed by
// data words; the channel index auto-increments across a burst.
//   clk, rst        : system clock, async active-high reset
//   sclk, cs, mosi  : SPI pins (asynchronous, oversampled in clk)
//   miso, oe_drv    : SPI data out and its driver enable
//   rd_data         : NREG read sources, channel k at [k*DATA_W +: DATA_W]
//   rd_stb, rd_adr  : word captured for readout (clear-on-read hook)
//   wr_stb, wr_adr, wr_data : completed write word
module spi_regbank_bpl
   import spi_bpl_pkg::*;
#(
   parameter int         DATA_W   = 8,
   parameter int         NREG     = 4,
   parameter logic [6:0] BASE_ADR = 7'h10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sclk,
   input  logic                     cs,
   input  logic                     mosi,
   output logic                     miso,
   output logic                     oe_drv,
   input  logic [NREG*DATA_W-1:0]   rd_data,
   output logic                     rd_stb,
   output logic [adr_w(NREG)-1:0]   rd_adr,
   output logic                     wr_stb,
   output logic [adr_w(NREG)-1:0]   wr_adr,
   output logic [DATA_W-1:0]        wr_data
);
   localparam int AW    = adr_w(NREG);
   // The final bit of a word is taken straight from mosi, so the shift
   // register is one bit shorter than the longest word.
   localparam int SH_W  = ((DATA_W > CMD_W) ? DATA_W : CMD_W) - 1;
   localparam int CNT_W = $clog2(SH_W + 2);

   logic sck_lvl, sck_rise, sck_fall;
   logic cs_lvl, cs_rise, cs_fall;

   spi_bpl_sync #(.INIT(1'b0)) u_sck_sync (
      .clk (clk), .rst (rst), .din (sclk),
      .lvl (sck_lvl), .rise (sck_rise), .fall (sck_fall)
   );

   spi_bpl_sync #(.INIT(1'b1)) u_cs_sync (
      .clk (clk), .rst (rst), .din (cs),
      .lvl (cs_lvl), .rise (cs_rise), .fall (cs_fall)
   );

   state_t            state, nxt;
   logic [1:0]        mosi_q;
   logic [CNT_W-1:0]  bit_cnt;
   logic [SH_W-1:0]   sh;
   logic [DATA_W-1:0] rd_sh;
   logic [AW-1:0]     ch;
   logic [1:0]        fill;
   logic              armed;

   logic              mosi_s, sck_r, sck_f;
   logic [CMD_W-1:0]  cmd_word;
   logic [6:0]        cmd_adr;
   logic [AW-1:0]     cmd_ch, load_ch;
   logic              in_win, cmd_done, word_done, last_ch, rd_load;

   // mosi is delayed to line up with the sclk stage that decodes the rise.
   assign mosi_s   = mosi_q[1];
   // A cs rise in the same cycle as an sclk edge discards the edge.
   assign sck_r    = sck_rise & ~cs_rise;
   assign sck_f    = sck_fall & ~cs_rise;

   assign cmd_word = {sh[CMD_W-2:0], mosi_s};
   assign cmd_adr  = cmd_word[CMD_W-2:0];
   assign in_win   = ({1'b0, cmd_adr} >= {1'b0, BASE_ADR}) &&
                     ({1'b0, cmd_adr} <  8'(BASE_ADR + NREG));
   assign cmd_ch   = AW'(cmd_adr - BASE_ADR);

   assign cmd_done  = (state == ST_CMD) && sck_r && (bit_cnt == CNT_W'(CMD_W-1));
   assign word_done = ((state == ST_RD) || (state == ST_WR)) && sck_r &&
                      (bit_cnt == CNT_W'(DATA_W-1));
   assign last_ch   = (ch == AW'(NREG-1));

   // Capture a read word on the command's last rise, or on the last rise
   // of a word when the next channel is still inside the window.
   assign rd_load = (cmd_done && in_win && !cmd_word[RW_BIT]) ||
                    ((state == ST_RD) && word_done && !last_ch);
   assign load_ch = (state == ST_CMD) ? cmd_ch : ch + AW'(1);
   assign rd_stb  = rd_load;
   assign rd_adr  = rd_load ? load_ch : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (cs_rise) begin
         nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (cs_fall && armed) nxt = ST_CMD;
            ST_CMD:  if (cmd_done) nxt = !in_win            ? ST_SKIP :
                                         cmd_word[RW_BIT]   ? ST_WR   : ST_RD;
            ST_RD,
            ST_WR:   if (word_done && last_ch) nxt = ST_SKIP;
            default: nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mosi_q  <= '0;
         bit_cnt <= '0;
         sh      <= '0;
         rd_sh   <= '0;
         ch      <= '0;
         fill    <= '0;
         armed   <= 1'b0;
         miso    <= 1'b1;
         oe_drv  <= 1'b0;
         wr_stb  <= 1'b0;
         wr_adr  <= '0;
         wr_data <= '0;
      end else begin
         mosi_q <= {mosi_q[0], mosi};
         wr_stb <= 1'b0;

         // Frames are accepted only after the synchronisers hold real
         // samples showing an idle bus, so cs held low through reset
         // release cannot masquerade as a fresh frame start.
         if (fill != 2'd3) fill <= fill + 2'd1;
         if (fill == 2'd3 && cs_lvl && !sck_lvl) armed <= 1'b1;

         if (state == ST_IDLE || cs_rise)
            bit_cnt <= '0;
         else if (sck_r && (state == ST_CMD || state == ST_RD || state == ST_WR))
            bit_cnt <= (cmd_done || word_done) ? '0 : bit_cnt + CNT_W'(1);

         if (sck_r && (state == ST_CMD || state == ST_WR))
            sh <= {sh[SH_W-2:0], mosi_s};

         if (cmd_done)
            ch <= cmd_ch;
         else if (word_done && !last_ch)
            ch <= ch + AW'(1);

         // The MSB is already presented after capture, so the fall that
         // follows the capturing rise must hold it rather than shift.
         if (rd_load)
            rd_sh <= rd_data[load_ch*DATA_W +: DATA_W];
         else if (state == ST_RD && sck_f && bit_cnt != '0)
            rd_sh <= {rd_sh[DATA_W-2:0], 1'b0};

         if (state == ST_WR && word_done) begin
            wr_stb  <= 1'b1;
            wr_adr  <= ch;
            wr_data <= {sh[DATA_W-2:0], mosi_s};
         end

         miso   <= (state == ST_RD) ? rd_sh[DATA_W-1] : 1'b1;
         oe_drv <= (state == ST_RD);
      end
   end
endmodule

// File: tb/tb_spi_regbank_bpl.sv
// Bench for spi_regbank_bpl: acts as SPI mode-0 master, predicts strobes
// and MISO words from the frame rules, and checks every cycle.
module tb_spi_regbank_bpl;
   localparam int DATA_W = 8;
   localparam int NREG   = 4;
   localparam int BASE   = 'h10;
   localparam int HALF   = 8;

   logic clk = 1'b0, rst = 1'b1;
   logic sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
   logic miso, oe_drv, rd_stb, wr_stb;
   logic [1:0] rd_adr, wr_adr;
   logic [7:0] wr_data;
   logic [NREG*DATA_W-1:0] rd_data;

   logic [7:0] rd_mem [4];
   logic [7:0] tx_w   [4];
   logic [7:0] last_rx;
   logic [1:0] exp_rd [$];
   logic [9:0] exp_wr [$];
   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   spi_regbank_bpl #(.DATA_W(DATA_W), .NREG(NREG), .BASE_ADR(7'h10)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
      .miso(miso), .oe_drv(oe_drv), .rd_data(rd_data),
      .rd_stb(rd_stb), .rd_adr(rd_adr),
      .wr_stb(wr_stb), .wr_adr(wr_adr), .wr_data(wr_data)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the expected strobe queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (!oe_drv) chk("miso_idle_high", 32'(miso), 32'd1);
         if (rd_stb) begin
            n_chk++;
            if (exp_rd.size() == 0) begin
               n_fail++;
               $display("FAIL rd_stb_unexpected: got rd_adr %0d expected no strobe", rd_adr);
            end else begin
               n_chk--;
               chk("rd_adr", 32'(rd_adr), 32'(exp_rd.pop_front()));
            end
         end
         if (wr_stb) begin
            n_chk++;
            if (exp_wr.size() == 0) begin
               n_fail++;
               $display("FAIL wr_stb_unexpected: got %0d/%h expected no strobe", wr_adr, wr_data);
            end else begin
               n_chk--;
               chk("wr_adr_data", 32'({wr_adr, wr_data}), 32'(exp_wr.pop_front()));
            end
         end
      end
   end

   task automatic shift_bits(input logic [7:0] tx, input int n,
                             output logic [7:0] rx, output logic [7:0] oe);
      rx = '0;
      oe = '0;
      for (int b = 0; b < n; b++) begin
         mosi = tx[7-b];
         repeat (HALF) @(negedge clk);
         rx = {rx[6:0], miso};
         oe = {oe[6:0], oe_drv};
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   // Frame of nwords words, the last one cut to last_bits bits.
   task automatic run_frame(input logic [7:0] cmd, input int nwords, input int last_bits);
      int start, ch, nb;
      bit inwin, rdf;
      logic [7:0] rx, oe, exp_rx, exp_oe;
      start = int'(cmd[6:0]) - BASE;
      inwin = (start >= 0) && (start < NREG);
      rdf   = !cmd[7];
      if (inwin) begin
         for (int w = 0; w <= nwords; w++) begin
            ch = start + w;
            nb = (w == nwords - 1) ? last_bits : 8;
            if (ch < NREG) begin
               // A read word is captured when the previous word completes,
               // including the one prefetched after the final full word.
               if (rdf && (w < nwords || last_bits == 8)) exp_rd.push_back(2'(ch));
               if (!rdf && w < nwords && nb == 8) exp_wr.push_back({2'(ch), tx_w[w]});
            end
         end
      end
      @(negedge clk);
      cs = 1'b0;
      repeat (HALF) @(negedge clk);
      shift_bits(cmd, 8, rx, oe);
      chk("cmd_oe", 32'(oe), 32'd0);
      for (int w = 0; w < nwords; w++) begin
         ch = start + w;
         nb = (w == nwords - 1) ? last_bits : 8;
         shift_bits(rdf ? 8'hFF : tx_w[w], nb, rx, oe);
         if (rdf && inwin && ch < NREG) begin
            exp_rx = rd_mem[ch] >> (8 - nb);
            exp_oe = 8'hFF >> (8 - nb);
         end else begin
            exp_rx = 8'hFF >> (8 - nb);
            exp_oe = 8'h00;
         end
         chk("miso_word", 32'(rx), 32'(exp_rx));
         chk("oe_word", 32'(oe), 32'(exp_oe));
         last_rx = rx;
      end
      repeat (HALF) @(negedge clk);
      cs = 1'b1;
      repeat (12) @(negedge clk);
      chk("oe_after_frame", 32'(oe_drv), 32'd0);
      chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
   endtask

   initial begin
      #1ms;
      n_fail++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rx, oe;
      rd_mem = '{8'h81, 8'h7E, 8'hA5, 8'hC9};
      rd_data = {rd_mem[3], rd_mem[2], rd_mem[1], rd_mem[0]};
      tx_w = '{8'h00, 8'h00, 8'h00, 8'h00};

      repeat (3) @(negedge clk);
      chk("rst_miso", 32'(miso), 32'd1);
      chk("rst_oe", 32'(oe_drv), 32'd0);
      chk("rst_rd_stb", 32'(rd_stb), 32'd0);
      chk("rst_wr_stb", 32'(wr_stb), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // single read of channel 2
      run_frame(8'h12, 1, 8);
      chk("lit_read_ch2", 32'(last_rx), 32'hA5);

      // write burst into channels 1 and 2
      tx_w[0] = 8'h3C; tx_w[1] = 8'hC3;
      run_frame(8'h91, 2, 8);
      chk("lit_wr_data", 32'(wr_data), 32'hC3);
      chk("lit_wr_adr", 32'(wr_adr), 32'd2);

      // read burst off the top of the window
      run_frame(8'h13, 2, 8);
      chk("lit_read_skip", 32'(last_rx), 32'hFF);

      // address outside window
      run_frame(8'h05, 1, 8);

      // aborted write after 5 bits
      tx_w[0] = 8'h5A;
      run_frame(8'h90, 1, 5);
      chk("lit_wr_hold", 32'(wr_data), 32'hC3);

      // normal read after abort
      run_frame(8'h11, 1, 8);
      chk("lit_read_ch1", 32'(last_rx), 32'h7E);

      // write burst overrunning the window
      tx_w[0] = 8'h11; tx_w[1] = 8'h22; tx_w[2] = 8'h33;
      run_frame(8'h92, 3, 8);
      chk("lit_wr_last", 32'({wr_adr, wr_data}), 32'h322);

      // reset in the middle of a read frame
      exp_rd.push_back(2'd2);
      @(negedge clk);
      cs = 1'b0;
      repeat (HALF) @(negedge clk);
      shift_bits(8'h12, 8, rx, oe);
      shift_bits(8'hFF, 3, rx, oe);
      chk("midrst_oe_before", 32'(oe), 32'h7);
      exp_rd.delete();
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_miso", 32'(miso), 32'd1);
      chk("midrst_oe", 32'(oe_drv), 32'd0);
      chk("midrst_rd_stb", 32'(rd_stb), 32'd0);
      chk("midrst_rd_adr", 32'(rd_adr), 32'd0);
      chk("midrst_wr_adr", 32'(wr_adr), 32'd0);
      chk("midrst_wr_data", 32'(wr_data), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      shift_bits(8'h12, 8, rx, oe);
      shift_bits(8'hFF, 8, rx, oe);
      chk("postrst_oe", 32'(oe), 32'd0);
      chk("postrst_miso", 32'(rx), 32'hFF);
      cs = 1'b1;
      repeat (12) @(negedge clk);
      run_frame(8'h10, 1, 8);
      chk("lit_read_ch0", 32'(last_rx), 32'h81);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
